// File: rtl/rgb_timing_gen.sv
// Runtime-programmable RGB/LCD timing generator: HS/VS/DE, pixel coordinates and a leading
// pixel-fetch request, with timing/polarity reloads taking effect only at frame boundaries.
module rgb_timing_gen #(
    parameter int CNT_W      = 12,
    parameter int DEF_H_ACT  = 800,
    parameter int DEF_H_FP   = 40,
    parameter int DEF_H_SYNC = 128,
    parameter int DEF_H_BP   = 88,
    parameter int DEF_V_ACT  = 480,
    parameter int DEF_V_FP   = 1,
    parameter int DEF_V_SYNC = 3,
    parameter int DEF_V_BP   = 21,
    parameter bit DEF_HS_POL = 1'b0,
    parameter bit DEF_VS_POL = 1'b0,
    parameter int PRE_REQ    = 2
) (
    input  logic             rgb_clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_wr,
    input  logic [CNT_W-1:0] cfg_h_act,
    input  logic [CNT_W-1:0] cfg_h_fp,
    input  logic [CNT_W-1:0] cfg_h_sync,
    input  logic [CNT_W-1:0] cfg_h_bp,
    input  logic [CNT_W-1:0] cfg_v_act,
    input  logic [CNT_W-1:0] cfg_v_fp,
    input  logic [CNT_W-1:0] cfg_v_sync,
    input  logic [CNT_W-1:0] cfg_v_bp,
    input  logic             cfg_hs_pol,
    input  logic             cfg_vs_pol,
    output logic             cfg_pending,
    output logic             running,
    output logic             rgb_hs,
    output logic             rgb_vs,
    output logic             rgb_de,
    output logic             data_req,
    output logic [CNT_W-1:0] rgb_x,
    output logic [CNT_W-1:0] rgb_y,
    output logic             frame_start,
    output logic             line_start
);

    typedef struct packed {
        logic [CNT_W-1:0] h_act;
        logic [CNT_W-1:0] h_fp;
        logic [CNT_W-1:0] h_sync;
        logic [CNT_W-1:0] h_bp;
        logic [CNT_W-1:0] v_act;
        logic [CNT_W-1:0] v_fp;
        logic [CNT_W-1:0] v_sync;
        logic [CNT_W-1:0] v_bp;
        logic             hs_pol;
        logic             vs_pol;
    } timing_t;

    timing_t def_set, cfg_set, applied, pending;

    assign def_set = '{h_act: CNT_W'(DEF_H_ACT), h_fp: CNT_W'(DEF_H_FP),
                       h_sync: CNT_W'(DEF_H_SYNC), h_bp: CNT_W'(DEF_H_BP),
                       v_act: CNT_W'(DEF_V_ACT), v_fp: CNT_W'(DEF_V_FP),
                       v_sync: CNT_W'(DEF_V_SYNC), v_bp: CNT_W'(DEF_V_BP),
                       hs_pol: DEF_HS_POL, vs_pol: DEF_VS_POL};

    assign cfg_set = '{h_act: cfg_h_act, h_fp: cfg_h_fp, h_sync: cfg_h_sync, h_bp: cfg_h_bp,
                       v_act: cfg_v_act, v_fp: cfg_v_fp, v_sync: cfg_v_sync, v_bp: cfg_v_bp,
                       hs_pol: cfg_hs_pol, vs_pol: cfg_vs_pol};

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic [CNT_W-1:0] h_sync_end, h_start, h_tot;
    logic [CNT_W-1:0] v_sync_end, v_start, v_tot;
    logic [CNT_W:0]   h_ahead;
    logic             h_last, v_last, boundary, apply;
    logic             hs_act, vs_act, h_de, v_de, de_now, req_now;

    always_comb begin
        h_sync_end = applied.h_fp + applied.h_sync;
        h_start    = h_sync_end + applied.h_bp;
        h_tot      = h_start + applied.h_act;
        v_sync_end = applied.v_fp + applied.v_sync;
        v_start    = v_sync_end + applied.v_bp;
        v_tot      = v_start + applied.v_act;
        h_last     = (h_cnt == h_tot - 1'b1);
        v_last     = (v_cnt == v_tot - 1'b1);
        boundary   = h_last && v_last;
        // Stopped: the applied set simply tracks any write, so config lands immediately.
        apply      = !running || boundary;
        hs_act     = (h_cnt >= applied.h_fp) && (h_cnt < h_sync_end);
        vs_act     = (v_cnt >= applied.v_fp) && (v_cnt < v_sync_end);
        h_de       = (h_cnt >= h_start);
        v_de       = (v_cnt >= v_start);
        de_now     = h_de && v_de;
        // Compare h+PRE_REQ against the active window so no subtraction can underflow.
        h_ahead    = {1'b0, h_cnt} + (CNT_W+1)'(PRE_REQ);
        req_now    = v_de && (h_ahead >= {1'b0, h_start}) && (h_ahead < {1'b0, h_tot});
    end

    always_ff @(posedge rgb_clk or posedge rst) begin
        if (rst) begin
            applied     <= def_set;
            pending     <= def_set;
            cfg_pending <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            running     <= 1'b0;
        end else begin
            if (cfg_wr)
                pending <= cfg_set;
            if (apply) begin
                applied     <= cfg_wr ? cfg_set : pending;
                cfg_pending <= 1'b0;
            end else if (cfg_wr) begin
                cfg_pending <= 1'b1;
            end

            if (!running) begin
                h_cnt   <= '0;
                v_cnt   <= '0;
                running <= en;
            end else if (h_last) begin
                h_cnt <= '0;
                if (v_last) begin
                    v_cnt   <= '0;
                    running <= en;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge rgb_clk or posedge rst) begin
        if (rst) begin
            rgb_hs      <= ~DEF_HS_POL;
            rgb_vs      <= ~DEF_VS_POL;
            rgb_de      <= 1'b0;
            data_req    <= 1'b0;
            rgb_x       <= '0;
            rgb_y       <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else if (!running) begin
            rgb_hs      <= ~applied.hs_pol;
            rgb_vs      <= ~applied.vs_pol;
            rgb_de      <= 1'b0;
            data_req    <= 1'b0;
            rgb_x       <= '0;
            rgb_y       <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            rgb_hs      <= hs_act ? applied.hs_pol : ~applied.hs_pol;
            rgb_vs      <= vs_act ? applied.vs_pol : ~applied.vs_pol;
            rgb_de      <= de_now;
            data_req    <= req_now;
            rgb_x       <= de_now ? h_cnt - h_start : '0;
            rgb_y       <= de_now ? v_cnt - v_start : '0;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            line_start  <= (h_cnt == '0);
        end
    end

endmodule

// File: tb/tb_rgb_timing_gen.sv
// Directed bench for rgb_timing_gen: small programmed timings, mid-frame and boundary
// reloads, en stop/restart and asynchronous reset back to the 1056x505 default timing.
module tb_rgb_timing_gen;

    localparam int CNT_W = 12;

    logic             rgb_clk = 1'b0;
    logic             rst, en, cfg_wr;
    logic [CNT_W-1:0] cfg_h_act, cfg_h_fp, cfg_h_sync, cfg_h_bp;
    logic [CNT_W-1:0] cfg_v_act, cfg_v_fp, cfg_v_sync, cfg_v_bp;
    logic             cfg_hs_pol, cfg_vs_pol;
    logic             cfg_pending, running, rgb_hs, rgb_vs, rgb_de, data_req;
    logic [CNT_W-1:0] rgb_x, rgb_y;
    logic             frame_start, line_start;

    int total = 0;
    int bad   = 0;

    // per-frame statistics, index 0 = the cycle frame_start is seen on the pins
    int len, n_de, n_req, n_hs_hi, n_vs_lo, n_ls;
    int de_first, de_last, req_first, req_last, x_last, y_last;
    int pend_after, pend_end;

    rgb_timing_gen #(.CNT_W(CNT_W), .PRE_REQ(2)) dut (
        .rgb_clk(rgb_clk), .rst(rst), .en(en), .cfg_wr(cfg_wr),
        .cfg_h_act(cfg_h_act), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
        .cfg_v_act(cfg_v_act), .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
        .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol),
        .cfg_pending(cfg_pending), .running(running),
        .rgb_hs(rgb_hs), .rgb_vs(rgb_vs), .rgb_de(rgb_de), .data_req(data_req),
        .rgb_x(rgb_x), .rgb_y(rgb_y), .frame_start(frame_start), .line_start(line_start)
    );

    always #5 rgb_clk = ~rgb_clk;

    task automatic step();
        @(negedge rgb_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int ha, hf, hsy, hb, va, vf, vsy, vb, input logic hp, vp);
        cfg_h_act = CNT_W'(ha); cfg_h_fp = CNT_W'(hf); cfg_h_sync = CNT_W'(hsy); cfg_h_bp = CNT_W'(hb);
        cfg_v_act = CNT_W'(va); cfg_v_fp = CNT_W'(vf); cfg_v_sync = CNT_W'(vsy); cfg_v_bp = CNT_W'(vb);
        cfg_hs_pol = hp; cfg_vs_pol = vp;
    endtask

    // Waits for frame_start, then records one frame until the next frame_start.
    // wr_at >= 0 pulses cfg_wr on that frame index.
    task automatic capture(input int wr_at);
        int  i;
        bit  done;
        i = 0;
        while (frame_start !== 1'b1 && i < 400) begin
            step();
            i++;
        end
        chk("frame_start_seen", frame_start, 1);
        n_de = 0; n_req = 0; n_hs_hi = 0; n_vs_lo = 0; n_ls = 0;
        de_first = -1; de_last = -1; req_first = -1; req_last = -1;
        x_last = -1; y_last = -1; pend_after = -1;
        i = 0;
        done = 0;
        while (!done) begin
            if ((i > 0 && frame_start === 1'b1) || i >= 400) begin
                done = 1;
            end else begin
                if (rgb_de === 1'b1) begin
                    n_de++;
                    if (de_first < 0) de_first = i;
                    de_last = i;
                    x_last  = int'(rgb_x);
                    y_last  = int'(rgb_y);
                end
                if (data_req === 1'b1) begin
                    n_req++;
                    if (req_first < 0) req_first = i;
                    req_last = i;
                end
                if (rgb_hs === 1'b1) n_hs_hi++;
                if (rgb_vs === 1'b0) n_vs_lo++;
                if (line_start === 1'b1) n_ls++;
                if (i == wr_at + 1) pend_after = int'(cfg_pending);
                if (i == wr_at) cfg_wr = 1'b1;
                step();
                cfg_wr = 1'b0;
                i++;
            end
        end
        len = i;
        pend_end = int'(cfg_pending);
    endtask

    initial begin
        int i;
        int hs_hi;

        rst = 1'b1; en = 1'b0; cfg_wr = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        step(); step();
        chk("rst_running", running, 0);
        chk("rst_pending", cfg_pending, 0);
        chk("rst_hs", rgb_hs, 1);
        chk("rst_vs", rgb_vs, 1);
        chk("rst_de", rgb_de, 0);
        rst = 1'b0;
        step();

        // Write while stopped: applied immediately, nothing left pending
        set_cfg(8, 2, 3, 4, 4, 1, 2, 2, 1'b0, 1'b0);
        cfg_wr = 1'b1;
        step();
        cfg_wr = 1'b0;
        chk("stopped_wr_pending", cfg_pending, 0);
        step();
        chk("stopped_hs_idle", rgb_hs, 1);

        // First frame: 17x9, DE 8 clk on 4 lines, data_req leads by 2
        en = 1'b1;
        capture(-1);
        chk("t1_len", len, 153);
        chk("t1_de_count", n_de, 32);
        chk("t1_de_first", de_first, 94);
        chk("t1_de_last", de_last, 152);
        chk("t1_x_last", x_last, 7);
        chk("t1_y_last", y_last, 3);
        chk("t1_hs_high", n_hs_hi, 126);
        chk("t1_vs_low", n_vs_lo, 34);
        chk("t1_line_starts", n_ls, 9);
        chk("t2_req_count", n_req, 32);
        chk("t2_req_first", req_first, 92);
        chk("t2_req_last", req_last, 150);

        // Mid-frame write: h_act=6, HS active-high; current frame keeps 17-clk lines
        set_cfg(6, 2, 3, 4, 4, 1, 2, 2, 1'b1, 1'b0);
        capture(20);
        chk("t3_len_old", len, 153);
        chk("t3_pending_set", pend_after, 1);
        chk("t3_pending_clr", pend_end, 0);

        // Frame with 15-clk lines; write back on the boundary cycle (counter at last pixel)
        set_cfg(8, 2, 3, 4, 4, 1, 2, 2, 1'b0, 1'b0);
        capture(133);
        chk("t3_len_new", len, 135);
        chk("t3_hs_high", n_hs_hi, 27);
        chk("t3_de_count", n_de, 24);
        chk("t3_de_first", de_first, 84);
        chk("t3_x_last", x_last, 5);
        chk("t4_bnd_pending", pend_after, 0);

        capture(-1);
        chk("t4_len", len, 153);
        chk("t4_hs_high", n_hs_hi, 126);
        chk("t4_req_count", n_req, 32);

        // Drop en on line 2: frame runs to completion, then idle
        i = 0;
        repeat (34) begin
            step();
            i++;
        end
        en = 1'b0;
        while (running === 1'b1 && i < 400) begin
            step();
            i++;
        end
        chk("t5_stop_index", i, 152);
        chk("t5_last_de", rgb_de, 1);
        chk("t5_last_x", rgb_x, 7);
        chk("t5_last_y", rgb_y, 3);
        step();
        chk("t5_idle_hs", rgb_hs, 1);
        chk("t5_idle_vs", rgb_vs, 1);
        chk("t5_idle_de", rgb_de, 0);
        chk("t5_idle_req", data_req, 0);
        chk("t5_idle_ls", line_start, 0);
        repeat (3) step();
        chk("t5_still_stopped", running, 0);
        en = 1'b1;
        step();
        chk("t5_restart_running", running, 1);
        step();
        chk("t5_restart_fs", frame_start, 1);
        chk("t5_restart_ls", line_start, 1);

        // Async reset in the middle of an active line
        i = 0;
        while (rgb_de !== 1'b1 && i < 400) begin
            step();
            i++;
        end
        chk("t6_de_reached", rgb_de, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_de", rgb_de, 0);
        chk("t6_async_hs", rgb_hs, 1);
        chk("t6_async_x", rgb_x, 0);
        chk("t6_async_running", running, 0);
        step();
        rst = 1'b0;

        // Default timing: 1056-clk lines with 128-clk active-low HS
        i = 0;
        while (line_start !== 1'b1 && i < 2000) begin
            step();
            i++;
        end
        chk("t6_first_ls", line_start, 1);
        chk("t6_first_fs", frame_start, 1);
        hs_hi = 0;
        i = 0;
        do begin
            if (rgb_hs === 1'b1) hs_hi++;
            step();
            i++;
        end while (line_start !== 1'b1 && i < 2000);
        chk("t6_line_len", i, 1056);
        chk("t6_hs_high", hs_hi, 928);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
